// File: rtl/mem_io_ctrl_pkg.sv
// Shared constants and types for the data-side memory/IO controller:
// IO address map, access FSM states and access targets.
package mem_io_ctrl_pkg;

  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;
  localparam logic [31:0] LED_ADDR   = 32'hFFFFFC60;
  localparam logic [31:0] SW_ADDR    = 32'hFFFFFC70;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_LED  = 2'd1,
    TGT_SW   = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  // IO registers match on the full byte address; everything outside the
  // top 1 KiB window is RAM.
  function automatic tgt_e decode_tgt(input logic [31:0] addr);
    if (addr[31:10] != IO_BASE_HI) return TGT_RAM;
    else if (addr == LED_ADDR)     return TGT_LED;
    else if (addr == SW_ADDR)      return TGT_SW;
    else                           return TGT_NONE;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset for bringing
// asynchronous board inputs into the clock domain.
module mem_io_ctrl_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Data-side memory/IO controller: steers loads/stores to data RAM or to the
// LED/switch registers and stalls the core for the duration of a load.
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 14,
  parameter int RAM_LAT    = 1,
  parameter int IO_WAIT    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  stall,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic [23:0]           switch_in,
  output logic [23:0]           led_out,
  output logic [1:0]            dbg_state
);

  localparam int CNT_MAX = (RAM_LAT > IO_WAIT) ? RAM_LAT : IO_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                state_q, state_d;
  tgt_e                  tgt_q, tgt_d;
  tgt_e                  req_tgt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [23:0]           led_q, led_d;
  logic [23:0]           sw_sync;

  mem_io_ctrl_sync2 #(.W(24)) u_sw_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (switch_in),
    .q_o   (sw_sync)
  );

  assign req_tgt = decode_tgt(alu_result);

  // A simultaneous read+write is a plain write; the read is dropped.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    led_d    = led_q;
    stall    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    case (state_q)
      IDLE: begin
        ram_addr = alu_result[RAM_ADDR_W+1:2];
        if (mem_write) begin
          ram_we = (req_tgt == TGT_RAM);
          if (req_tgt == TGT_LED) led_d = write_data[23:0];
        end else if (mem_read) begin
          stall   = ~reset;
          addr_d  = alu_result[RAM_ADDR_W+1:2];
          tgt_d   = req_tgt;
          cnt_d   = (req_tgt == TGT_RAM) ? CNT_W'(RAM_LAT) : CNT_W'(IO_WAIT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          case (tgt_q)
            TGT_RAM: rdata_d = ram_rdata;
            TGT_SW:  rdata_d = {8'h00, sw_sync};
            default: rdata_d = 32'h0;
          endcase
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= TGT_RAM;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  assign read_data = rdata_q;
  assign led_out   = led_q;
  assign ram_wdata = write_data;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: directed scenarios followed by random loads/stores,
// checked against a word-level model of RAM, LED register and switches.
module tb_mem_io_ctrl;
  import mem_io_ctrl_pkg::*;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_LAT    = 1;
  localparam int IO_WAIT    = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  mem_read = 1'b0;
  logic                  mem_write = 1'b0;
  logic [31:0]           alu_result = '0;
  logic [31:0]           write_data = '0;
  logic [31:0]           read_data;
  logic                  stall;
  logic                  ram_we;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata = '0;
  logic [23:0]           switch_in = '0;
  logic [23:0]           led_out;
  logic [1:0]            dbg_state;

  mem_io_ctrl #(.RAM_ADDR_W(RAM_ADDR_W), .RAM_LAT(RAM_LAT), .IO_WAIT(IO_WAIT)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .alu_result(alu_result), .write_data(write_data), .read_data(read_data),
    .stall(stall), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .switch_in(switch_in), .led_out(led_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // external synchronous data RAM, one-cycle read latency, 256 words visible
  logic [31:0] ext_ram [0:255];
  always @(posedge clock) begin
    if (ram_we) ext_ram[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ext_ram[ram_addr[7:0]];
  end

  // reference model state
  logic [31:0] ref_mem [0:255];
  logic [23:0] led_model = '0;
  logic [31:0] last_read = '0;

  int tests = 0;
  int fails = 0;

  logic [RAM_ADDR_W+31:0] exp_wr_q[$];
  logic [31:0]            exp_rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return a[31:10] == 22'h3FFFFF;
  endfunction

  // scoreboard monitor: RAM writes and completed loads
  logic prev_stall = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_we) begin
        if (exp_wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ram_we: got addr %h data %h expected no write", ram_addr, ram_wdata);
        end else begin
          check("ram_write", {ram_addr, ram_wdata}, exp_wr_q.pop_front());
        end
      end
      if (prev_stall && !stall) begin
        if (exp_rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_load_done: got %h expected no load", read_data);
        end else begin
          check("load_data", read_data, exp_rd_q.pop_front());
        end
      end
      prev_stall = stall;
    end
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit also_read);
    if (!is_io(addr)) exp_wr_q.push_back({addr[RAM_ADDR_W+1:2], data});
    mem_write = 1'b1; mem_read = also_read; alu_result = addr; write_data = data;
    @(negedge clock);
    check("store_stall", stall, 0);
    if (also_read) check("rw_read_data_hold", read_data, last_read);
    @(posedge clock); #1;
    mem_write = 1'b0; mem_read = 1'b0; alu_result = $urandom;
    if (!is_io(addr)) ref_mem[addr[9:2]] = data;
    else if (addr == 32'hFFFFFC60) led_model = data[23:0];
    check("led_out", led_out, led_model);
  endtask

  task automatic do_load(input logic [31:0] addr);
    int n;
    int lat;
    logic [31:0] exp;
    lat = is_io(addr) ? IO_WAIT : RAM_LAT;
    if (!is_io(addr))             exp = ref_mem[addr[9:2]];
    else if (addr == 32'hFFFFFC70) exp = {8'h00, switch_in};
    else                          exp = 32'h0;
    exp_rd_q.push_back(exp);
    last_read = exp;
    mem_read = 1'b1; mem_write = 1'b0; alu_result = addr; write_data = $urandom;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!stall) break;
      n++;
      if (!is_io(addr)) check("load_ram_addr", ram_addr, addr[RAM_ADDR_W+1:2]);
    end
    check("load_stall_len", n, 1 + lat);
    @(posedge clock); #1;
    mem_read = 1'b0; alu_result = $urandom;
  endtask

  task automatic set_switches(input logic [23:0] v);
    switch_in = v;
    idle(3);
  endtask

  function automatic logic [31:0] rand_ram_addr();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_other_io();
    logic [31:0] a;
    do a = {22'h3FFFFF, 8'($urandom), 2'b00};
    while (a == 32'hFFFFFC60 || a == 32'hFFFFFC70);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      ext_ram[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
  end

  initial begin
    int op;
    logic [31:0] a;
    logic [31:0] d;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_stall", stall, 0);
    check("reset_read_data", read_data, 0);
    check("reset_led_out", led_out, 0);
    check("reset_ram_we", ram_we, 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge clock); #1;

    do_store(32'h0000_0010, 32'hDEADBEEF, 1'b0);
    do_load(32'h0000_0010);
    do_store(32'hFFFF_FC60, 32'h00AB_CDEF, 1'b0);
    do_store(32'hFFFF_FC64, 32'h1111_2222, 1'b0);
    do_store(32'h0001_FFF8, 32'hCAFE_F00D, 1'b0);
    do_load(32'h0001_FFF8);
    set_switches(24'h123456);
    do_load(32'hFFFF_FC70);
    do_store(32'h0000_0020, 32'h5A5A_5A5A, 1'b1);
    do_load(32'h0000_0020);
    do_load(32'hFFFF_FC60);
    do_load(32'hFFFF_FC40);

    // reset during the second WAIT cycle of a switch load
    do_load(32'h0000_0010);
    mem_read = 1'b1; alu_result = 32'hFFFF_FC70;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("abort_stall", stall, 0);
    check("abort_read_data", read_data, 0);
    check("abort_led_out", led_out, 0);
    mem_read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    last_read = '0;
    led_model = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("post_abort_stall", stall, 0);
      check("post_abort_read_data", read_data, 0);
    end
    check("post_abort_state", dbg_state, IDLE);
    @(posedge clock); #1;
    idle(2);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 7);
      d  = $urandom;
      case (op)
        0: do_store(rand_ram_addr(), d, 1'b0);
        1: do_load(rand_ram_addr());
        2: do_store(32'hFFFF_FC60, d, 1'b0);
        3: do_store(rand_other_io(), d, 1'b0);
        4: do_load(32'hFFFF_FC70);
        5: do_load(rand_other_io());
        6: do_store(rand_ram_addr(), d, 1'b1);
        default: set_switches(24'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check("pending_writes", exp_wr_q.size(), 0);
    check("pending_loads", exp_rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
